// File: rtl/ibex_zkn_aes32_unit_if.sv
// Request/response bundle between the operand path, the AES32 unit and writeback.
// The master drives requests and accepts results; the slave is the unit.
interface ibex_zkn_aes32_unit_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  op_i;
    logic [1:0]  bs_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        illegal_o;

    modport master (
        output in_valid_i, op_i, bs_i, rs1_i, rs2_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, illegal_o
    );

    modport slave (
        input  in_valid_i, op_i, bs_i, rs1_i, rs2_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, illegal_o
    );
endinterface

// File: rtl/ibex_zkn_aes32_unit.sv
// AES32 round-step unit (aes32esi/esmi/dsi/dsmi) with valid/ready on both sides.
// Define IBEX_ZKN_AES_DEC_EN to build the inverse S-box and InvMixColumn path.
module ibex_zkn_aes32_unit #(
    parameter int unsigned SboxPipe = 0
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    ibex_zkn_aes32_unit_if.slave bus
);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ m;
            m = xt(m);
        end
        return p;
    endfunction

    // a^254 is the field inverse; 0 maps to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

`ifdef IBEX_ZKN_AES_DEC_EN
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    endfunction
`endif

    function automatic logic [31:0] mix_col(input logic [1:0] op, input logic [7:0] s);
        logic [7:0]  s2;
        logic [31:0] c;
        s2 = xt(s);
        c  = {24'h000000, s};
        if (op == 2'b01) c = {s2 ^ s, s, s, s2};
`ifdef IBEX_ZKN_AES_DEC_EN
        begin
            logic [7:0] s4;
            logic [7:0] s8;
            s4 = xt(s2);
            s8 = xt(s4);
            if (op == 2'b11) c = {s8 ^ s2 ^ s, s8 ^ s4 ^ s, s8 ^ s, s8 ^ s4 ^ s2};
        end
`endif
        return c;
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] c, input logic [1:0] bs);
        case (bs)
            2'd1:    return {c[23:0], c[31:24]};
            2'd2:    return {c[15:0], c[31:16]};
            2'd3:    return {c[7:0],  c[31:8]};
            default: return c;
        endcase
    endfunction

    logic [7:0]  x_in;
    logic [7:0]  s_in;
    logic        ill_in;
    logic        first_ready;
    logic        in_ready;
    logic        in_fire;
    logic        out_adv;
    logic        feed_valid;
    logic [7:0]  feed_s;
    logic [1:0]  feed_op;
    logic [1:0]  feed_bs;
    logic [31:0] feed_rs1;
    logic        feed_ill;
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;

    // Forward and inverse S-box share one field inverter
    always_comb begin
        x_in = bus.rs2_i[{bus.bs_i, 3'b000} +: 8];
`ifdef IBEX_ZKN_AES_DEC_EN
        s_in = gf_inv(bus.op_i[1] ? inv_affine(x_in) : x_in);
        if (!bus.op_i[1]) s_in = affine(s_in);
        ill_in = 1'b0;
`else
        s_in   = affine(gf_inv(x_in));
        ill_in = bus.op_i[1];
`endif
    end

    assign out_adv        = !out_valid_q || bus.out_ready_i;
    assign in_ready       = first_ready && !bus.flush_i;
    assign in_fire        = bus.in_valid_i && in_ready;
    assign bus.in_ready_o = in_ready;

    if (SboxPipe != 0) begin : g_s1
        logic        s1_valid_q, s1_valid_d;
        logic [7:0]  s1_s_q, s1_s_d;
        logic [1:0]  s1_op_q, s1_op_d;
        logic [1:0]  s1_bs_q, s1_bs_d;
        logic [31:0] s1_rs1_q, s1_rs1_d;
        logic        s1_ill_q, s1_ill_d;

        assign first_ready = !s1_valid_q || out_adv;

        always_comb begin
            s1_valid_d = bus.flush_i ? 1'b0 : ((s1_valid_q && !out_adv) || in_fire);
            s1_s_d     = s1_s_q;
            s1_op_d    = s1_op_q;
            s1_bs_d    = s1_bs_q;
            s1_rs1_d   = s1_rs1_q;
            s1_ill_d   = s1_ill_q;
            if (in_fire) begin
                s1_s_d   = s_in;
                s1_op_d  = bus.op_i;
                s1_bs_d  = bus.bs_i;
                s1_rs1_d = bus.rs1_i;
                s1_ill_d = ill_in;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_valid_q <= 1'b0;
                s1_s_q     <= 8'h00;
                s1_op_q    <= 2'b00;
                s1_bs_q    <= 2'b00;
                s1_rs1_q   <= 32'h0;
                s1_ill_q   <= 1'b0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_s_q     <= s1_s_d;
                s1_op_q    <= s1_op_d;
                s1_bs_q    <= s1_bs_d;
                s1_rs1_q   <= s1_rs1_d;
                s1_ill_q   <= s1_ill_d;
            end
        end

        assign feed_valid = s1_valid_q;
        assign feed_s     = s1_s_q;
        assign feed_op    = s1_op_q;
        assign feed_bs    = s1_bs_q;
        assign feed_rs1   = s1_rs1_q;
        assign feed_ill   = s1_ill_q;
    end else begin : g_bypass
        assign first_ready = out_adv;
        assign feed_valid  = in_fire;
        assign feed_s      = s_in;
        assign feed_op     = bus.op_i;
        assign feed_bs     = bus.bs_i;
        assign feed_rs1    = bus.rs1_i;
        assign feed_ill    = ill_in;
    end

    // Output stage: flush wins over a simultaneous result transfer
    always_comb begin
        out_valid_d = bus.flush_i ? 1'b0 : (out_adv ? feed_valid : out_valid_q);
        result_d    = result_q;
        illegal_d   = illegal_q;
        if (out_adv && feed_valid) begin
            illegal_d = feed_ill;
            result_d  = feed_ill ? 32'h0 : (rotl_bytes(mix_col(feed_op, feed_s), feed_bs) ^ feed_rs1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'h0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.illegal_o   = illegal_q;

endmodule

// File: tb/tb_ibex_zkn_aes32_unit.sv
// Scoreboard bench for ibex_zkn_aes32_unit: one instance per SboxPipe setting,
// random traffic against a table-driven AES model plus known-answer vectors.
module tb_ibex_zkn_aes32_unit;
`ifdef IBEX_ZKN_AES_DEC_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        drv_valid = 1'b0;
    logic        sel = 1'b0;
    logic        drv_flush = 1'b0;
    logic        rdy0 = 1'b1;
    logic        rdy1 = 1'b1;
    logic        rand_rdy = 1'b0;
    logic [1:0]  drv_op = 2'b00;
    logic [1:0]  drv_bs = 2'b00;
    logic [31:0] drv_rs1 = 32'h0;
    logic [31:0] drv_rs2 = 32'h0;
    logic        sel_ready;

    int   checks = 0;
    int   failures = 0;
    int   npop0 = 0;
    int   npop1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] sbox_t[256];
    logic [7:0] isbox_t[256];

    always #5 clk = ~clk;

    ibex_zkn_aes32_unit_if if0 ();
    ibex_zkn_aes32_unit_if if1 ();

    assign if0.in_valid_i  = drv_valid && !sel;
    assign if1.in_valid_i  = drv_valid && sel;
    assign if0.flush_i     = drv_flush && !sel;
    assign if1.flush_i     = drv_flush && sel;
    assign if0.op_i        = drv_op;
    assign if1.op_i        = drv_op;
    assign if0.bs_i        = drv_bs;
    assign if1.bs_i        = drv_bs;
    assign if0.rs1_i       = drv_rs1;
    assign if1.rs1_i       = drv_rs1;
    assign if0.rs2_i       = drv_rs2;
    assign if1.rs2_i       = drv_rs2;
    assign if0.out_ready_i = rdy0;
    assign if1.out_ready_i = rdy1;
    assign sel_ready       = sel ? if1.in_ready_o : if0.in_ready_o;

    ibex_zkn_aes32_unit #(.SboxPipe(0)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0.slave));
    ibex_zkn_aes32_unit #(.SboxPipe(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                       ^ inv[(i + 7) % 8] ^ c[i];
            sbox_t[x]  = s;
            isbox_t[s] = 8'(x);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [1:0] bs,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [7:0]  x;
        logic [7:0]  s;
        logic [31:0] col;
        logic [7:0]  k3, k2, k1, k0;
        if (op[1] && !DEC) begin
            e.res = 32'h0;
            e.ill = 1'b1;
            return e;
        end
        x = r2[{bs, 3'b000} +: 8];
        s = op[1] ? isbox_t[x] : sbox_t[x];
        case (op)
            2'b01:   {k3, k2, k1, k0} = {8'h03, 8'h01, 8'h01, 8'h02};
            2'b11:   {k3, k2, k1, k0} = {8'h0b, 8'h0d, 8'h09, 8'h0e};
            default: {k3, k2, k1, k0} = {8'h00, 8'h00, 8'h00, 8'h01};
        endcase
        col = {gmul(s, k3), gmul(s, k2), gmul(s, k1), gmul(s, k0)};
        for (int i = 0; i < int'(bs); i++) col = {col[23:0], col[31:24]};
        e.res = col ^ r1;
        e.ill = 1'b0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int qsz(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic mon(input int k, input logic fl, input logic iv, input logic ir,
                       input logic ov, input logic ordy, input logic [31:0] res,
                       input logic ill, input logic [1:0] op, input logic [1:0] bs,
                       input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        if (!rst_n || fl) begin
            if (k == 0) q0.delete();
            else q1.delete();
            return;
        end
        if (ov) begin
            if (qsz(k) == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_u%0d_unexpected actual=%h/%b required=no output", k, res, ill);
            end else begin
                e = (k == 0) ? q0[0] : q1[0];
                chk((k == 0) ? "sb_u0" : "sb_u1", 64'({ill, res}), 64'({e.ill, e.res}));
                if (ordy) begin
                    if (k == 0) begin
                        void'(q0.pop_front());
                        npop0++;
                    end else begin
                        void'(q1.pop_front());
                        npop1++;
                    end
                end
            end
        end
        if (iv && ir) begin
            e = model(op, bs, r1, r2);
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.flush_i, if0.in_valid_i, if0.in_ready_o, if0.out_valid_o, if0.out_ready_i,
            if0.result_o, if0.illegal_o, if0.op_i, if0.bs_i, if0.rs1_i, if0.rs2_i);
        mon(1, if1.flush_i, if1.in_valid_i, if1.in_ready_o, if1.out_valid_o, if1.out_ready_i,
            if1.result_o, if1.illegal_o, if1.op_i, if1.bs_i, if1.rs1_i, if1.rs2_i);
    end

    always @(posedge clk) begin
        #2;
        if (rand_rdy) begin
            rdy0 = $urandom_range(0, 3) != 0;
            rdy1 = $urandom_range(0, 3) != 0;
        end
    end

    // Entered and left at posedge+1; in_valid stays high for back-to-back issue.
    task automatic req(input logic [1:0] op, input logic [1:0] bs,
                       input logic [31:0] r1, input logic [31:0] r2);
        int n = 0;
        drv_op    = op;
        drv_bs    = bs;
        drv_rs1   = r1;
        drv_rs2   = r2;
        drv_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sel_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL req_timeout actual=no accept required=accept within 100 cycles");
                drv_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain(input int k);
        int n = 0;
        while (qsz(k) != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(qsz(k)), 64'd0);
    endtask

    task automatic kat(input string nm, input logic [1:0] op, input logic [1:0] bs,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] exp_res, input logic exp_ill, input int lat);
        int n;
        logic ov;
        req(op, bs, r1, r2);
        drv_valid = 1'b0;
        n  = 1;
        ov = sel ? if1.out_valid_o : if0.out_valid_o;
        while (!ov && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            ov = sel ? if1.out_valid_o : if0.out_valid_o;
        end
        chk({nm, "_lat"}, 64'(n), 64'(lat));
        chk({nm, "_res"}, 64'(sel ? if1.result_o : if0.result_o), 64'(exp_res));
        chk({nm, "_ill"}, 64'(sel ? if1.illegal_o : if0.illegal_o), 64'(exp_ill));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input logic k, input int n);
        sel      = k;
        rand_rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            req(2'($urandom), 2'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 4) == 0) begin
                drv_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drv_valid = 1'b0;
        drain(int'(k));
        rand_rdy = 1'b0;
        rdy0     = 1'b1;
        rdy1     = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        logic saw_drop;
        build_tables();
        #12;
        chk("rst_ov0", 64'(if0.out_valid_o), 64'd0);
        chk("rst_res0", 64'(if0.result_o), 64'd0);
        chk("rst_ill0", 64'(if0.illegal_o), 64'd0);
        chk("rst_ov1", 64'(if1.out_valid_o), 64'd0);
        chk("rst_res1", 64'(if1.result_o), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy0", 64'(if0.in_ready_o), 64'd1);
        chk("rst_rdy1", 64'(if1.in_ready_o), 64'd1);

        sel = 1'b0;
        kat("esm_bs0", 2'b01, 2'd0, 32'h0, 32'h0, 32'ha56363c6, 1'b0, 1);
        kat("esm_bs1", 2'b01, 2'd1, 32'h0, 32'h0, 32'h6363c6a5, 1'b0, 1);
        kat("es_53", 2'b00, 2'd1, 32'hffffffff, 32'h00005300, 32'hffff12ff, 1'b0, 1);
        kat("ds_63", 2'b10, 2'd0, 32'h0, 32'h00000063, 32'h0, !DEC, 1);
        kat("dsm_0", 2'b11, 2'd0, 32'h0, 32'h0, DEC ? 32'h50a7f451 : 32'h0, !DEC, 1);
        sel = 1'b1;
        kat("p1_esm_bs0", 2'b01, 2'd0, 32'h0, 32'h0, 32'ha56363c6, 1'b0, 2);
        kat("p1_dsm_0", 2'b11, 2'd0, 32'h0, 32'h0, DEC ? 32'h50a7f451 : 32'h0, !DEC, 2);

        rand_phase(1'b0, 150);
        rand_phase(1'b1, 150);

        sel      = 1'b1;
        rdy1     = 1'b1;
        base     = npop1;
        saw_drop = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    req(2'($urandom), 2'($urandom), $urandom, $urandom);
                drv_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 rdy1 = 1'b0;
                repeat (3) @(posedge clk);
                #1 rdy1 = 1'b1;
            end
            begin
                repeat (12) begin
                    @(negedge clk);
                    if (drv_valid && !if1.in_ready_o) saw_drop = 1'b1;
                end
            end
        join
        drain(1);
        chk("stall_count", 64'(npop1 - base), 64'd8);
        chk("stall_ready_drop", 64'(saw_drop), 64'd1);

        rdy1 = 1'b0;
        req(2'b01, 2'($urandom), $urandom, $urandom);
        req(2'b00, 2'($urandom), $urandom, $urandom);
        chk("flush_pre_ov", 64'(if1.out_valid_o), 64'd1);
        drv_flush = 1'b1;
        drv_rs2   = $urandom;
        @(negedge clk);
        chk("flush_in_ready", 64'(if1.in_ready_o), 64'd0);
        @(posedge clk);
        #1;
        drv_flush = 1'b0;
        drv_valid = 1'b0;
        chk("flush_ov", 64'(if1.out_valid_o), 64'd0);
        rdy1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("flush_no_out", 64'(if1.out_valid_o), 64'd0);
        end

        rdy1 = 1'b0;
        req(2'b01, 2'd2, $urandom, $urandom);
        req(2'b01, 2'd3, $urandom, $urandom);
        drv_valid = 1'b0;
        sel  = 1'b0;
        rdy0 = 1'b0;
        req(2'b01, 2'd0, 32'h0, 32'h0);
        drv_valid = 1'b0;
        chk("arst_pre_ov0", 64'(if0.out_valid_o), 64'd1);
        chk("arst_pre_ov1", 64'(if1.out_valid_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov0", 64'(if0.out_valid_o), 64'd0);
        chk("arst_res0", 64'(if0.result_o), 64'd0);
        chk("arst_ov1", 64'(if1.out_valid_o), 64'd0);
        chk("arst_res1", 64'(if1.result_o), 64'd0);
        chk("arst_ill1", 64'(if1.illegal_o), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        #1;
        chk("arst_rdy0", 64'(if0.in_ready_o), 64'd1);
        chk("arst_rdy1", 64'(if1.in_ready_o), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_s1_gone", 64'(if1.out_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ibex_zkn_aes32_unit.md
# ibex_zkn_aes32_unit

Pipelined AES32 round-step unit for the Zkn crypto extension: performs one byte-column step of AES encryption or decryption (aes32esi, aes32esmi, aes32dsi, aes32dsmi) with valid/ready handshakes on both sides and optional internal pipelining. It sits between the ID/EX operand path and the writeback mux.

## Interface
Parameters:
- SboxPipe, default 0: 0 gives 1-cycle latency (output register only); 1 adds a register after the S-box, giving 2-cycle latency.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  request valid
- in_ready_o  out  1  unit accepts a request this cycle
- op_i  in  2  00 ES (encrypt final), 01 ESM (encrypt middle), 10 DS (decrypt final), 11 DSM (decrypt middle)
- bs_i  in  2  byte select
- rs1_i  in  32  round-key word, XORed into the result
- rs2_i  in  32  state word; byte bs_i is the S-box input
- flush_i  in  1  drop all in-flight requests
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  32  result word
- illegal_o  out  1  op not supported in this build; qualified by out_valid_o

## Operation
- Request transfers when in_valid_i && in_ready_o. Result transfers when out_valid_o && out_ready_i.
- x = rs2_i[8*bs_i +: 8]. s = forward S-box(x) for ES/ESM, inverse S-box(x) for DS/DSM.
- Field mult: xt(a) = {a[6:0],0} ^ (a[7] ? 8'h1b : 0); 2s = xt(s), 4s = xt(2s), 8s = xt(4s).
- Column c (bytes [31:24..7:0]):
  - ES/DS: {0,0,0,s}.
  - ESM: {3s, s, s, 2s}, where 3s = 2s^s.
  - DSM: {0b·s, 0d·s, 09·s, 0e·s}; 09 = 8s^s, 0b = 8s^2s^s, 0d = 8s^4s^s, 0e = 8s^4s^2s.
- result = rotl32(c, 8*bs_i) ^ rs1_i.
- Pipeline stages (S1 only when SboxPipe=1, plus OUT) each hold valid + payload. A stage holds while its downstream is stalled; never drops or duplicates data.
- in_ready_o = !first_stage_valid || first_stage_advances (combinational from out_ready_i; full throughput, one result/cycle).
- Illegal op: result_o = 0, illegal_o = 1, still takes normal latency and handshake.

## Timing
- Reset: out_valid_o = 0, result_o = 0, illegal_o = 0, all stage valids 0; in_ready_o = 1 after reset.
- Latency from input transfer to out_valid_o: 1 cycle (SboxPipe=0), 2 cycles (SboxPipe=1), absent stalls.
- result_o/illegal_o stable while out_valid_o && !out_ready_i.
- flush_i: all stage valids clear next edge; a request presented in the flush cycle is not accepted (in_ready_o = 0 while flush_i = 1). Flush dominates a simultaneous output transfer (output considered consumed).
- Simultaneous in/out transfer on a full pipe: both occur, occupancy unchanged.
- Async reset mid-operation: all in-flight requests discarded immediately.

## Configuration
- IBEX_ZKN_AES_DEC_EN defined: inverse S-box and InvMixColumn logic built; DS/DSM legal.
- Not defined: no decryption logic; DS/DSM complete with result_o = 0, illegal_o = 1; ES/ESM unchanged.

## Test plan
- ESM, SboxPipe=0, rs2=0x00000000, rs1=0, bs=0 -> one cycle later result 0xa56363c6, illegal 0; same with bs=1 -> 0x6363c6a5.
- ES, rs2=0x00005300, bs=1, rs1=0xffffffff -> result 0xffff12ff (S(0x53)=0xed); DS, rs2=0x63, bs=0, rs1=0 -> 0x00000000.
- DSM with IBEX_ZKN_AES_DEC_EN, rs2=0, bs=0, rs1=0 -> 0x50a7f451; without the macro -> result 0, illegal_o 1.
- SboxPipe=1, back-to-back 8 requests, out_ready_i held low 3 cycles mid-stream -> in_ready_o drops, all 8 results in order, none lost or repeated, outputs stable during stall.
- flush_i with 2 requests in flight and in_valid_i high -> next cycle out_valid_o 0, flush-cycle request not accepted.
- rst_ni asserted asynchronously mid-stream -> out_valid_o, result_o, illegal_o 0 immediately; in_ready_o 1 after release.
